// File: rtl/sd_transfer_sequencer.sv
// sd_transfer_sequencer: turns host block requests into SD controller transfers.
// It waits for the card to initialise, range-checks each request, retries failed attempts and pulses one response per request.
module sd_transfer_sequencer #(
    parameter logic [31:0] MAX_RETRY = 32'd3,
    parameter logic [31:0] TIMEOUT   = 32'd2000000,
    parameter logic [31:0] GAP       = 32'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_lba,
    input  logic [31:0] req_count,
    output logic        rsp_done,
    output logic [2:0]  rsp_err,
    output logic [2:0]  rsp_attempts,
    output logic        SD_Enable,
    output logic        SD_we,
    output logic [31:0] SD_Addr_Block,
    output logic [31:0] SD_SerialCount,
    input  logic        SD_Complite,
    input  logic        SD_Fail,
    input  logic        SD_Init_Complite,
    input  logic        SD_Init_Fail,
    input  logic [21:0] SD_DeviseSize
);
    typedef enum logic [2:0] {WAIT_INIT, IDLE, CHECK, ISSUE, WAIT_DONE, RELEASE, RESPOND, INIT_FAULT} state_t;
    state_t      state, state_n;
    logic        we_q, ok, faulted, ready_n, en_n, load_n, clear, timed_out;
    logic [31:0] lba_q, cnt_q, tcnt, gcnt;
    logic [2:0]  att, err_q, err_n;
    logic [32:0] cap, span;

    // 33-bit arithmetic so an LBA near 2^32 cannot wrap past the capacity check
    assign cap       = ({11'd0, SD_DeviseSize} + 33'd1) << 10;
    assign span      = {1'b0, lba_q} + {1'b0, cnt_q};
    assign clear     = !SD_Complite && !SD_Fail;
    assign timed_out = tcnt == TIMEOUT - 32'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= WAIT_INIT;
            err_q          <= 3'd0;
            req_ready      <= 1'b0;
            rsp_done       <= 1'b0;
            rsp_err        <= 3'd0;
            rsp_attempts   <= 3'd0;
            SD_Enable      <= 1'b0;
            SD_we          <= 1'b0;
            SD_Addr_Block  <= 32'd0;
            SD_SerialCount <= 32'd0;
            we_q           <= 1'b0;
            lba_q          <= 32'd0;
            cnt_q          <= 32'd0;
            att            <= 3'd0;
            tcnt           <= 32'd0;
            gcnt           <= 32'd0;
            ok             <= 1'b0;
            faulted        <= 1'b0;
        end else begin
            state        <= state_n;
            err_q        <= err_n;
            req_ready    <= ready_n;
            SD_Enable    <= en_n;
            rsp_done     <= state == RESPOND;
            rsp_err      <= state == RESPOND ? err_q : 3'd0;
            rsp_attempts <= state == RESPOND ? att : 3'd0;
            faulted      <= faulted || state_n == INIT_FAULT;
            att          <= (state == IDLE || state == INIT_FAULT) ? 3'd0 : (state == ISSUE && att != 3'd7) ? att + 3'd1 : att;
            tcnt         <= state == WAIT_DONE ? tcnt + 32'd1 : 32'd0;
            // the gap only counts cycles where the controller has dropped both status lines
            gcnt         <= (state == RELEASE && clear) ? gcnt + 32'd1 : 32'd0;
            if (state == IDLE && req_valid) {we_q, lba_q, cnt_q} <= {req_we, req_lba, req_count};
            if (state == WAIT_DONE) ok <= SD_Complite && !SD_Fail;
            if (load_n) {SD_we, SD_Addr_Block, SD_SerialCount} <= {we_q, lba_q, cnt_q};
        end
    end

    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            WAIT_INIT:  state_n = SD_Init_Fail ? INIT_FAULT : SD_Init_Complite ? IDLE : WAIT_INIT;
            IDLE:       state_n = req_valid ? CHECK : IDLE;
            CHECK: begin
                state_n = (cnt_q == 32'd0 || span > cap) ? RESPOND : ISSUE;
                err_n   = cnt_q == 32'd0 ? 3'd4 : 3'd2;
            end
            ISSUE:      state_n = WAIT_DONE;
            WAIT_DONE:  state_n = (SD_Complite || SD_Fail || timed_out) ? RELEASE : WAIT_DONE;
            RELEASE: if (clear && gcnt + 32'd1 >= GAP) begin
                state_n = (ok || {29'd0, att} > MAX_RETRY) ? RESPOND : ISSUE;
                err_n   = ok ? 3'd0 : 3'd3;
            end
            RESPOND:    state_n = faulted ? INIT_FAULT : IDLE;
            INIT_FAULT: if (req_valid) begin
                state_n = RESPOND;
                err_n   = 3'd1;
            end
        endcase
    end

    always_comb begin
        ready_n = state_n == IDLE || state_n == INIT_FAULT;
        en_n    = state_n == WAIT_DONE;
        load_n  = state_n == ISSUE;
    end
endmodule
